// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// fetch_entry_t is the RV32 view of one fetch-buffer entry, provided for decode.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO holding fetched entries; flush empties it in one cycle.
// Storage is not reset: an empty buffer never exposes it to the consumer.
module fetch_buffer #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem, buffers {pc, insn, fault} for decode.
// A faulted fetch parks the stage until execute redirects it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              AWIDTH    = 32,
    parameter int              DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter int              DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] imem_addr_o,
    output logic              imem_read_en_o,
    input  logic [DWIDTH-1:0] imem_data_i,
    input  logic              imem_valid_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic              fault_o
);

    localparam int EW = AWIDTH + DWIDTH + 1;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              buf_full, buf_empty;
    logic              pop, can_push, push, aligned, fetch_ok;
    logic [EW-1:0]     push_entry, head_entry;

    assign aligned  = (pc_q[1:0] == 2'b00);
    assign fetch_ok = aligned & imem_valid_i;

    // A redirect hides the head so no handshake can complete in that cycle.
    assign valid_o  = ~buf_empty & ~redirect_i;
    assign pop      = valid_o & ready_i;
    assign can_push = ~buf_full | pop;
    assign push     = (state_q == RUN) & can_push & ~redirect_i;

    assign imem_addr_o    = pc_q;
    assign imem_read_en_o = push & aligned;

    assign push_entry = fetch_ok ? {pc_q, imem_data_i, 1'b0}
                                 : {pc_q, {DWIDTH{1'b0}}, 1'b1};

    assign {pc_o, insn_o, fault_o} = buf_empty ? '0 : head_entry;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_i) begin
            pc_d    = redirect_pc_i;
            state_d = RUN;
        end else if (push) begin
            if (fetch_ok) pc_d    = pc_q + AWIDTH'(4);
            else          state_d = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, faults and reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0;
    int pop_snap;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr_o    (imem_addr),
        .imem_read_en_o (imem_read_en),
        .imem_data_i    (imem_data),
        .imem_valid_i   (imem_valid),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .valid_o        (valid),
        .ready_i        (ready),
        .pc_o           (pc),
        .insn_o         (insn),
        .fault_o        (fault)
    );

    always #5 clk = ~clk;

    // Memory: 64 words at BASE; words 0/1 are real instructions, the rest C0DE0000+index.
    logic [31:0] mem_idx;
    always_comb begin
        mem_idx    = (imem_addr - BASE) >> 2;
        imem_valid = (imem_addr >= BASE) && (imem_addr < BASE + 32'h100);
        if (mem_idx == 32'd0)      imem_data = 32'h00500093;
        else if (mem_idx == 32'd1) imem_data = 32'h00A00113;
        else                       imem_data = 32'hC0DE0000 | mem_idx;
    end

    always @(posedge clk) begin
        if (!rst && valid && ready) pop_cnt <= pop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] epc, input logic [31:0] einsn,
                        input logic efault);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".insn"}, insn, einsn);
        chk({tag, ".fault"}, 32'(fault), 32'(efault));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.pc", pc, 32'd0);
        chk("rst.insn", insn, 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.addr", imem_addr, BASE);
        chk("rst.count", 32'(dut.u_buf.count_q), 32'd0);

        // cycle 1: first fetch at BASE
        rst = 1'b0; #1;
        chk("c1.rden", 32'(imem_read_en), 32'd1);
        chk("c1.valid", 32'(valid), 32'd0);

        // cycle 2: first entry, then hold ready low for 5 cycles
        step(); ready = 1'b0; #1;
        head("c2", BASE, 32'h00500093, 1'b0);
        chk("c2.rden", 32'(imem_read_en), 32'd1);
        for (int k = 3; k <= 6; k++) begin
            step();
            head("bp", BASE, 32'h00500093, 1'b0);
            chk("bp.rden", 32'(imem_read_en), 32'd0);
            chk("bp.count", 32'(dut.u_buf.count_q), 32'd2);
        end

        // release: order preserved
        step(); ready = 1'b1; #1;
        head("rel0", BASE, 32'h00500093, 1'b0);
        chk("rel0.rden", 32'(imem_read_en), 32'd1);
        step(); head("rel1", BASE + 4, 32'h00A00113, 1'b0);
        step(); head("rel2", BASE + 8, 32'hC0DE0002, 1'b0);
        step(); head("rel3", BASE + 12, 32'hC0DE0003, 1'b0);
        chk("rel3.count", 32'(dut.u_buf.count_q), 32'd2);

        // redirect with two entries buffered
        redirect = 1'b1; redirect_pc = BASE + 32'h40; #1;
        chk("rd1.valid", 32'(valid), 32'd0);
        chk("rd1.rden", 32'(imem_read_en), 32'd0);
        step(); redirect = 1'b0; #1;
        chk("rd1n.valid", 32'(valid), 32'd0);
        chk("rd1n.count", 32'(dut.u_buf.count_q), 32'd0);
        chk("rd1n.addr", imem_addr, BASE + 32'h40);
        chk("rd1n.rden", 32'(imem_read_en), 32'd1);
        step(); head("rd1a", BASE + 32'h40, 32'hC0DE0010, 1'b0);
        step(); head("rd1b", BASE + 32'h44, 32'hC0DE0011, 1'b0);

        // misaligned redirect
        redirect = 1'b1; redirect_pc = BASE + 32'h42; #1;
        chk("rd2.valid", 32'(valid), 32'd0);
        step(); redirect = 1'b0; #1;
        chk("mis.rden", 32'(imem_read_en), 32'd0);
        chk("mis.addr", imem_addr, BASE + 32'h42);
        step();
        head("mis", BASE + 32'h42, 32'h0, 1'b1);
        chk("mis.rden2", 32'(imem_read_en), 32'd0);
        step();
        chk("mis.after", 32'(valid), 32'd0);
        chk("mis.state", 32'(dut.state_q), 32'(FAULT));
        chk("mis.rden3", 32'(imem_read_en), 32'd0);
        step();
        chk("mis.hold", 32'(dut.state_q), 32'(FAULT));
        chk("mis.valid2", 32'(valid), 32'd0);
        redirect = 1'b1; redirect_pc = BASE; #1;
        step(); redirect = 1'b0; #1;
        chk("res.rden", 32'(imem_read_en), 32'd1);
        chk("res.addr", imem_addr, BASE);
        step(); head("res", BASE, 32'h00500093, 1'b0);

        // out-of-range fetch at BASE+0x100
        redirect = 1'b1; redirect_pc = BASE + 32'hFC; #1;
        step(); redirect = 1'b0; #1;
        chk("oor.rden", 32'(imem_read_en), 32'd1);
        step(); head("oor.last", BASE + 32'hFC, 32'hC0DE003F, 1'b0);
        step(); ready = 1'b0; #1;
        head("oor.flt", BASE + 32'h100, 32'h0, 1'b1);
        chk("oor.rden2", 32'(imem_read_en), 32'd0);
        chk("oor.state", 32'(dut.state_q), 32'(FAULT));
        step();
        head("oor.hold", BASE + 32'h100, 32'h0, 1'b1);
        pop_snap = pop_cnt;
        redirect = 1'b1; ready = 1'b1; redirect_pc = BASE; #1;
        chk("race.valid", 32'(valid), 32'd0);
        step(); redirect = 1'b0; #1;
        chk("race.pops", 32'(pop_cnt), 32'(pop_snap));
        chk("race.count", 32'(dut.u_buf.count_q), 32'd0);
        chk("race.state", 32'(dut.state_q), 32'(RUN));
        chk("race.valid2", 32'(valid), 32'd0);
        chk("race.rden", 32'(imem_read_en), 32'd1);

        // reset with two entries buffered
        step(); ready = 1'b0; #1;
        head("pre", BASE, 32'h00500093, 1'b0);
        step();
        chk("pre.count", 32'(dut.u_buf.count_q), 32'd2);
        rst = 1'b1; #1;
        step(); rst = 1'b0; #1;
        chk("mrst.valid", 32'(valid), 32'd0);
        chk("mrst.pc", pc, 32'd0);
        chk("mrst.count", 32'(dut.u_buf.count_q), 32'd0);
        chk("mrst.addr", imem_addr, BASE);
        chk("mrst.rden", 32'(imem_read_en), 32'd1);
        step(); head("mrst.first", BASE, 32'h00500093, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory; owns the PC.
- Drives the memory address and read enable, and captures the combinational read data plus its valid flag into a 2-entry fetch buffer.
- Presents {pc, insn, fault} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump target) that flush the buffer.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, instruction width; fixed at 32 for RV32.
- BASE_ADDR, 32'h01000000, reset PC; equals memory base address.
- DEPTH, 2, fetch-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_addr_o  out  AWIDTH  memory read address (= pc_q)
- imem_read_en_o  out  1  memory read enable
- imem_data_i  in  DWIDTH  combinational read data, little-endian word
- imem_valid_i  in  1  memory read valid; low = address out of range
- redirect_i  in  1  redirect request from execute
- redirect_pc_i  in  AWIDTH  redirect target
- valid_o  out  1  buffer head valid to decode
- ready_i  in  1  decode accepts head
- pc_o  out  AWIDTH  PC of head entry
- insn_o  out  DWIDTH  instruction of head entry
- fault_o  out  1  head entry is a fetch fault

Behaviour:
- Reset is synchronous on rst and overrides everything else: pc_q=BASE_ADDR, count=0, rd/wr pointers=0, state=RUN.
  - valid_o=0; pc_o, insn_o and fault_o read 0 while the buffer is empty.
- States:
  - RUN: fetching.
  - FAULT: fetch halted after a faulted entry is pushed; exits only on redirect or reset.
- pop = valid_o & ready_i.
- can_push = (count<DEPTH) | pop.
- imem_addr_o = pc_q.
- imem_read_en_o = (state==RUN) & can_push & ~redirect_i & (pc_q[1:0]==0).
- Push (RUN, can_push, no redirect):
  - Normal: if pc_q[1:0]==0 and imem_valid_i, push {pc_q, imem_data_i, 0} and set pc_q<=pc_q+4.
    - The add wraps modulo 2^AWIDTH.
  - Fault: if pc_q misaligned or imem_valid_i=0, push {pc_q, 32'h0, 1} and go to FAULT; pc_q holds.
- Latency: one instruction per cycle sustained. An instruction at pc_q appears on valid_o the cycle after it is read.
- Head outputs are registered buffer contents. Head data is stable while valid_o & ~ready_i.
- Simultaneous push and pop at count==DEPTH is legal; count is unchanged.
- Redirect (redirect_i=1) has priority over push and pop:
  - count<=0 and pointers reset, discarding all entries.
  - pc_q<=redirect_pc_i unmodified; misalignment is caught as a fault on the next fetch.
  - state<=RUN.
  - valid_o is forced 0 combinationally in the redirect cycle, so no handshake completes.
- Back-to-back redirects: the last one wins; no fetch occurs in any redirect cycle.
- Reset asserted mid-stream drops all entries; fetch restarts at BASE_ADDR on the first cycle after rst deasserts.
- No combinational path from ready_i to imem_addr_o. The path from ready_i to imem_read_en_o is allowed.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, insn, fault}.
  - enum fetch_state_e {RUN, FAULT}.
  - constant NOP_INSN=32'h00000013, for decode use.
- Sub-module fetch_buffer: parameterised DEPTH-entry synchronous FIFO with push/pop/flush, full/empty and count.
- fetch_unit holds the PC, FSM and memory interface.

Test Plan:
- Reset, ready_i=1, memory holds 0x00500093, 0x00A00113 at 0x01000000/04:
  - valid_o high from cycle 2 after rst release.
  - Outputs (pc,insn) = (0x01000000, 0x00500093), then (0x01000004, 0x00A00113), one per cycle.
- Backpressure: ready_i=0 for 5 cycles after the first entry:
  - count saturates at 2; imem_read_en_o=0; head stays (0x01000000, 0x00500093).
  - Release ready_i: order is preserved with no drop or duplicate.
- Redirect to 0x01000040 while 2 entries are buffered:
  - valid_o=0 in the redirect cycle.
  - Next delivered pc_o=0x01000040; flushed entries are never delivered.
- Redirect to 0x01000042 (misaligned):
  - Single entry pc_o=0x01000042, insn_o=0, fault_o=1; imem_read_en_o stays 0.
  - FSM holds FAULT until a redirect to 0x01000000 resumes normal fetch.
- imem_valid_i=0 at pc 0x01000100:
  - Fault entry is delivered and fetch halts.
  - Simultaneous redirect and ready_i=1 in a later cycle: redirect wins and no pop is counted.
- rst asserted for 1 cycle with 2 entries buffered:
  - valid_o=0 next cycle; pc restarts at 0x01000000.
